// File: rtl/ahb3lite_sram_slave.sv
// ahb3lite_sram_slave: AHB-Lite responder fronting a word-organised scratch RAM with optional wait states.
// Define AHB3LITE_SRAM_WRPROT_EN to reject user-mode writes to the lowest quarter of the memory.
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HWORD   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int NB = HDATA_SIZE / 8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic                    dp_valid, dp_write;
    logic [IW-1:0]           dp_idx, rd_idx;
    logic [1:0]              dp_off;
    logic [2:0]              dp_size;
    logic [HDATA_SIZE-1:0]   mem [MEM_DEPTH];
    logic [HADDR_SIZE-1:0]   widx;
    logic [NB-1:0]           lanes;
    logic [HDATA_SIZE-1:0]   bmask, rd_word;
    logic                    accept, err, prot_err, wait_last, commit, rd_load;
    logic                    unused;

    assign unused = ^{HBURST, HPROT};
    assign widx   = HADDR >> 2;
    assign accept = HSEL & HREADY & (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
`ifdef AHB3LITE_SRAM_WRPROT_EN
    assign prot_err = HWRITE & ~HPROT[1] & (widx < HADDR_SIZE'(MEM_DEPTH / 4));
`else
    assign prot_err = 1'b0;
`endif
    assign err = (HSIZE > HSIZE_WORD)
               | (HSIZE == HSIZE_HWORD && HADDR[0])
               | (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)
               | (widx >= HADDR_SIZE'(MEM_DEPTH))
               | prot_err;
    assign wait_last = cnt == 4'(WAIT_STATES - 1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state)
            S_IDLE, S_ERR2: begin
                HRESP     = state == S_ERR2 ? HRESP_ERROR : HRESP_OKAY;
                cnt_nxt   = 4'd0;
                state_nxt = !accept ? S_IDLE : err ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                HREADYOUT = 1'b0;
                cnt_nxt   = wait_last ? 4'd0 : cnt + 4'd1;
                state_nxt = wait_last ? S_IDLE : S_WAIT;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_nxt = S_ERR2;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Little-endian byte lanes of the pending data phase.
    always_comb begin
        lanes = dp_size == HSIZE_BYTE  ? NB'(1) << dp_off :
                dp_size == HSIZE_HWORD ? NB'(3) << dp_off : {NB{1'b1}};
        bmask = '0;
        for (int i = 0; i < NB; i++) bmask[8*i +: 8] = {8{lanes[i]}};
    end

    assign commit  = dp_valid & dp_write & HREADYOUT;
    assign rd_idx  = state == S_WAIT ? dp_idx : widx[IW-1:0];
    // A write committing on the same edge a read samples the word is merged in (bypass).
    assign rd_word = (commit && dp_idx == rd_idx) ? (mem[rd_idx] & ~bmask) | (HWDATA & bmask)
                                                   : mem[rd_idx];
    assign rd_load = (accept & ~err & ~HWRITE & (WAIT_STATES == 0))
                   | (state == S_WAIT & wait_last & ~dp_write);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_off   <= 2'b00;
            dp_size  <= 3'b000;
            HRDATA   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (HREADYOUT) dp_valid <= accept & ~err;
            if (HREADYOUT && accept) begin
                dp_write <= HWRITE;
                dp_idx   <= widx[IW-1:0];
                dp_off   <= HADDR[1:0];
                dp_size  <= HSIZE;
            end
            if (rd_load) HRDATA <= rd_word;
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) mem[dp_idx] <= (mem[dp_idx] & ~bmask) | (HWDATA & bmask);
    end
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// tb_ahb3lite_sram_slave: directed bench for a zero-wait and a two-wait-state instance sharing one bus.
module tb_ahb3lite_sram_slave;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SQ = 2'b11;
    localparam logic [2:0] BYTE = 3'd0, HWORD = 3'd1, WORD = 3'd2, DWORD = 3'd3;

    logic        clk = 1'b0, rst_n = 1'b0, sel0 = 1'b1, sel2 = 1'b0, hwrite = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [2:0]  hsize = WORD, hburst = 3'd0;
    logic [3:0]  hprot = 4'b0011;
    logic [1:0]  htrans = IDLE;
    logic        hready, rdy0, rdy2, resp0, resp2;
    logic [31:0] rdata0, rdata2;
    int          tests = 0, fails = 0;
    logic [31:0] bexp [4] = '{32'hC0FFEE00, 32'hC0FFEE01, 32'hC0FFEE02, 32'hC0FFEE03};

    always #5 clk = ~clk;
    assign hready = sel2 ? rdy2 : rdy0;

    ahb3lite_sram_slave #(.WAIT_STATES(0)) u0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(rdata0),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HREADY(hready), .HREADYOUT(rdy0), .HRESP(resp0));

    ahb3lite_sram_slave #(.WAIT_STATES(2)) u2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel2), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(rdata2),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HREADY(hready), .HREADYOUT(rdy2), .HRESP(resp2));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic ap(input logic [1:0] t, input logic w, input logic [2:0] s, input logic [31:0] a);
        htrans = t;
        hwrite = w;
        hsize  = s;
        haddr  = a;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Packs {HREADYOUT,HRESP} so one comparison covers both.
    task automatic phase(input string tag, input logic r, input logic p);
        chk(tag, {30'b0, rdy0, resp0}, {30'b0, r, p});
    endtask

    task automatic phase2(input string tag, input logic r, input logic p);
        chk(tag, {30'b0, rdy2, resp2}, {30'b0, r, p});
    endtask

    initial begin
        #1;
        phase("rst0", 1, 0);
        chk("rst0_rdata", rdata0, 32'h0);
        phase2("rst2", 1, 0);
        chk("rst2_rdata", rdata2, 32'h0);
        #11 rst_n = 1'b1;
        // zero-wait write then read of the same word
        ap(NS, 1, WORD, 32'h10); step;
        hwdata = 32'hDEADBEEF; ap(NS, 0, WORD, 32'h10);
        phase("t1_wr", 1, 0); step;
        ap(IDLE, 0, WORD, 0);
        phase("t1_rd", 1, 0);
        chk("t1_rdata", rdata0, 32'hDEADBEEF);
        // byte write merged into an immediately following read
        ap(NS, 1, WORD, 32'h10); step;
        hwdata = 32'h11223344; ap(NS, 1, BYTE, 32'h13); step;
        hwdata = 32'hA5FFFFFF; ap(NS, 0, WORD, 32'h10); step;
        ap(IDLE, 0, WORD, 0);
        chk("t2_bypass", rdata0, 32'hA5223344); step;
        phase("idle_dp", 1, 0);
        chk("idle_hold", rdata0, 32'hA5223344);
        // error responses
        hwdata = 32'h0; ap(NS, 1, DWORD, 32'h10); step;
        ap(IDLE, 0, WORD, 0); hwdata = 32'hFFFFFFFF;
        phase("dword_e1", 0, 1); step;
        phase("dword_e2", 1, 1); step;
        phase("post_err", 1, 0);
        ap(NS, 0, HWORD, 32'h1); step;
        ap(IDLE, 0, WORD, 0);
        phase("hw_e1", 0, 1); step;
        phase("hw_e2", 1, 1);
        chk("err_hold", rdata0, 32'hA5223344);
        ap(NS, 1, WORD, 32'h410); step;
        hwdata = 32'hBAD0BAD0; ap(IDLE, 0, WORD, 0);
        phase("oor_e1", 0, 1); step;
        phase("oor_e2", 1, 1);
        ap(NS, 0, WORD, 32'h10); step;
        ap(IDLE, 0, WORD, 0);
        phase("err2_accept", 1, 0);
        chk("mem_unchanged", rdata0, 32'hA5223344);
        // INCR4 write burst with a BUSY beat, then read back
        hburst = 3'b011;
        ap(NS, 1, WORD, 32'h20); step;
        hwdata = bexp[0]; ap(SQ, 1, WORD, 32'h24); step;
        hwdata = bexp[1]; ap(BUSY, 1, WORD, 32'h28); step;
        phase("busy_dp", 1, 0);
        hwdata = 32'h0; ap(SQ, 1, WORD, 32'h28); step;
        hwdata = bexp[2]; ap(SQ, 1, WORD, 32'h2C); step;
        hwdata = bexp[3]; ap(IDLE, 0, WORD, 0); step;
        for (int i = 0; i < 4; i++) begin
            ap(i == 0 ? NS : SQ, 0, WORD, 32'h20 + 32'(4 * i)); step;
            chk($sformatf("burst_rd%0d", i), rdata0, bexp[i]);
        end
        ap(IDLE, 0, WORD, 0); hburst = 3'd0; step;
        // two wait states on the second instance
        sel0 = 1'b0; sel2 = 1'b1;
        ap(NS, 1, WORD, 32'h30); step;
        hwdata = 32'hCAFEF00D; ap(IDLE, 0, WORD, 0);
        phase2("w_wait1", 0, 0); step;
        phase2("w_wait2", 0, 0); step;
        phase2("w_final", 1, 0);
        ap(NS, 0, WORD, 32'h30); step;
        ap(IDLE, 0, WORD, 0);
        phase2("r_wait1", 0, 0);
        chk("r_hold", rdata2, 32'h0); step;
        phase2("r_wait2", 0, 0); step;
        phase2("r_final", 1, 0);
        chk("r_data", rdata2, 32'hCAFEF00D);
        // reset in the middle of a waited write drops it
        ap(NS, 1, WORD, 32'h30); step;
        hwdata = 32'h12345678; ap(IDLE, 0, WORD, 0);
        phase2("rst_pre", 0, 0);
        #2 rst_n = 1'b0;
        #1 phase2("rst_async", 1, 0);
        chk("rst_rdata", rdata2, 32'h0);
        step;
        #3 rst_n = 1'b1;
        ap(NS, 0, WORD, 32'h30); step;
        ap(IDLE, 0, WORD, 0); step; step;
        phase2("after_rst", 1, 0);
        chk("write_dropped", rdata2, 32'hCAFEF00D);
        sel2 = 1'b0; sel0 = 1'b1; step;
`ifdef AHB3LITE_SRAM_WRPROT_EN
        hprot = 4'b0010; ap(NS, 1, WORD, 32'h4); step;
        hwdata = 32'h600DF00D; hprot = 4'b0000; ap(NS, 1, WORD, 32'h4);
        phase("wp_priv", 1, 0); step;
        hwdata = 32'hBAADBAAD; ap(IDLE, 0, WORD, 0);
        phase("wp_e1", 0, 1); step;
        phase("wp_e2", 1, 1);
        hprot = 4'b0011; ap(NS, 0, WORD, 32'h4); step;
        ap(IDLE, 0, WORD, 0);
        chk("wp_unchanged", rdata0, 32'h600DF00D);
        step;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
